// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART defines: byte width and FIFO sizing helpers used by the
// receiver, the receive buffer and its reusable FIFO core.
package uart_rx_fifo_pkg;

  localparam int unsigned UART_BYTE_WIDTH = 8;
  localparam int unsigned UART_DATA_WIDTH = UART_BYTE_WIDTH;
  localparam int unsigned UART_FIFO_DEPTH_LOG2 = 4;

  // Number of entries for a FIFO addressed by log2 bits of pointer.
  function automatic int unsigned fifo_depth(input int unsigned log2);
    return 32'd1 << log2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Generic synchronous FIFO with registered pointers and count; head entry is
// presented show-ahead. Write while full is accepted only if a read frees a slot.
module sync_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2,
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned DEPTH = fifo_depth(DEPTH_LOG2);
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CNT_W-1:0]      cnt;
  logic                  rd_fire;
  logic                  wr_fire;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign count   = cnt;
  assign rd_data = mem[rd_ptr];

  // A read on a full FIFO makes room for a write in the same cycle.
  assign rd_fire = rd_en & ~empty;
  assign wr_fire = wr_en & (~full | rd_fire);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      case ({wr_fire, rd_fire})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; stale contents are hidden by the count.
  always_ff @(posedge clk) begin
    if (!reset && wr_fire) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures one byte per rising edge of the receiver's
// ready flag, queues it, and reports fill level and a sticky overrun flag.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2,
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic                  I_clk,
  input  logic                  I_reset,
  input  logic                  I_rx_ready,
  input  logic [DATA_WIDTH-1:0] I_rx_data,
  input  logic                  I_read,
  input  logic                  I_clear_overrun,
  output logic [DATA_WIDTH-1:0] O_data,
  output logic                  O_valid,
  output logic                  O_full,
  output logic [DEPTH_LOG2:0]   O_count,
  output logic                  O_overrun
);

  logic                  rx_prev;
  logic                  wr_req;
  logic                  drop;
  logic                  overrun;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DEPTH_LOG2:0]   fifo_count;
  logic [DATA_WIDTH-1:0] head;

  // rx_prev resets high so a level already present at reset release is ignored.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      rx_prev <= 1'b1;
    end else begin
      rx_prev <= I_rx_ready;
    end
  end

  assign wr_req = I_rx_ready & ~rx_prev;
  assign drop   = wr_req & fifo_full & ~I_read;

  sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk     (I_clk),
    .reset   (I_reset),
    .wr_en   (wr_req),
    .wr_data (I_rx_data),
    .rd_en   (I_read),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // A new drop takes precedence over a clear in the same cycle.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (I_clear_overrun) begin
      overrun <= 1'b0;
    end
  end

  assign O_valid   = ~fifo_empty;
  assign O_full    = fifo_full;
  assign O_count   = fifo_count;
  assign O_overrun = overrun;
  assign O_data    = fifo_empty ? '0 : head;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo with hand-computed expectations.
module tb_uart_rx_fifo;

  logic       clk;
  logic       reset;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rd;
  logic       clr;
  logic [7:0] data;
  logic       valid;
  logic       full;
  logic [4:0] count;
  logic       overrun;

  int errors = 0;
  int checks = 0;

  uart_rx_fifo #(.DEPTH_LOG2(4), .DATA_WIDTH(8)) dut (
    .I_clk           (clk),
    .I_reset         (reset),
    .I_rx_ready      (rx_ready),
    .I_rx_data       (rx_data),
    .I_read          (rd),
    .I_clear_overrun (clr),
    .O_data          (data),
    .O_valid         (valid),
    .O_full          (full),
    .O_count         (count),
    .O_overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Single-cycle ready pulse followed by one idle cycle.
  task automatic write_byte(input logic [7:0] d);
    rx_ready = 1'b1;
    rx_data  = d;
    tick();
    rx_ready = 1'b0;
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"}, 32'(data), 32'h0);
    chk({tag, "_valid"}, 32'(valid), 32'h0);
    chk({tag, "_full"}, 32'(full), 32'h0);
    chk({tag, "_count"}, 32'(count), 32'h0);
    chk({tag, "_ovr"}, 32'(overrun), 32'h0);
  endtask

  initial begin
    reset = 1'b1; rx_ready = 1'b0; rx_data = 8'h00; rd = 1'b0; clr = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk_all_zero("reset");

    // Single byte in and out.
    rx_ready = 1'b1; rx_data = 8'hA5;
    tick();
    rx_ready = 1'b0;
    chk("t1_valid", 32'(valid), 32'h1);
    chk("t1_data", 32'(data), 32'hA5);
    chk("t1_count", 32'(count), 32'h1);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("t1_rd_valid", 32'(valid), 32'h0);
    chk("t1_rd_data", 32'(data), 32'h0);
    chk("t1_rd_count", 32'(count), 32'h0);

    // Held level writes once.
    rx_ready = 1'b1; rx_data = 8'h3C;
    repeat (5) tick();
    rx_ready = 1'b0;
    tick();
    chk("t2_count", 32'(count), 32'h1);
    chk("t2_data", 32'(data), 32'h3C);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("t2_drain", 32'(count), 32'h0);

    // Fill, overflow, drain in order.
    for (int i = 0; i < 16; i++) write_byte(8'(i));
    chk("t3_full", 32'(full), 32'h1);
    chk("t3_count", 32'(count), 32'd16);
    chk("t3_ovr_pre", 32'(overrun), 32'h0);
    write_byte(8'hFF);
    chk("t3_ovr", 32'(overrun), 32'h1);
    chk("t3_count_drop", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t3_rd%0d", i), 32'(data), 32'(i));
      rd = 1'b1;
      tick();
    end
    rd = 1'b0;
    chk("t3_empty_count", 32'(count), 32'h0);
    chk("t3_empty_valid", 32'(valid), 32'h0);
    chk("t3_empty_data", 32'(data), 32'h0);
    chk("t3_ovr_sticky", 32'(overrun), 32'h1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t3_clr", 32'(overrun), 32'h0);

    // Full FIFO: simultaneous write and read, pointer wrap.
    for (int i = 0; i < 16; i++) write_byte(8'h20 + 8'(i));
    rx_ready = 1'b1; rx_data = 8'h77; rd = 1'b1;
    tick();
    rx_ready = 1'b0; rd = 1'b0;
    chk("t4_ovr", 32'(overrun), 32'h0);
    chk("t4_count", 32'(count), 32'd16);
    chk("t4_full", 32'(full), 32'h1);
    chk("t4_head", 32'(data), 32'h21);
    for (int i = 0; i < 15; i++) begin
      rd = 1'b1;
      tick();
    end
    rd = 1'b0;
    chk("t4_last", 32'(data), 32'h77);
    chk("t4_last_count", 32'(count), 32'h1);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("t4_drain", 32'(count), 32'h0);

    // Empty FIFO: simultaneous write and read; then read on empty.
    rx_ready = 1'b1; rx_data = 8'h11; rd = 1'b1;
    tick();
    rx_ready = 1'b0; rd = 1'b0;
    chk("t5_count", 32'(count), 32'h1);
    chk("t5_data", 32'(data), 32'h11);
    rd = 1'b1;
    tick();
    chk("t5_drain", 32'(count), 32'h0);
    tick();
    rd = 1'b0;
    chk("t5_rd_empty_count", 32'(count), 32'h0);
    chk("t5_rd_empty_valid", 32'(valid), 32'h0);
    chk("t5_rd_empty_ovr", 32'(overrun), 32'h0);

    // Overrun set beats clear; clear alone works.
    for (int i = 0; i < 16; i++) write_byte(8'h40 + 8'(i));
    write_byte(8'h99);
    chk("t6_ovr", 32'(overrun), 32'h1);
    rx_ready = 1'b1; rx_data = 8'h55; clr = 1'b1;
    tick();
    rx_ready = 1'b0; clr = 1'b0;
    chk("t6_set_wins", 32'(overrun), 32'h1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t6_clr", 32'(overrun), 32'h0);
    chk("t6_count", 32'(count), 32'd16);
    chk("t6_head", 32'(data), 32'h40);
    rd = 1'b1;
    repeat (8) tick();
    rd = 1'b0;
    chk("t6_count8", 32'(count), 32'd8);
    chk("t6_head8", 32'(data), 32'h48);

    // Reset mid-stream discards everything.
    reset = 1'b1;
    tick();
    chk_all_zero("t6_reset");

    // High level at reset release must not write.
    rx_ready = 1'b1; rx_data = 8'hC3;
    tick();
    reset = 1'b0;
    tick();
    tick();
    rx_ready = 1'b0;
    tick();
    chk("t7_no_write", 32'(count), 32'h0);
    chk("t7_valid", 32'(valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of the UART receiver. It captures each byte the receiver flags as ready, stores it in a small synchronous FIFO, and presents it to the CPU/bus side through a show-ahead read interface. It reports fill level and a sticky overrun flag, so software can poll instead of servicing every byte within one character time.

## Interface
Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (depth = 16 entries)
- DATA_WIDTH, 8, byte width; must match the receiver's data output

Ports:
- I_clk  in  1  system clock, all logic on rising edge
- I_reset  in  1  reset, synchronous, active-high
- I_rx_ready  in  1  byte-ready flag from receiver; a write happens on its rising edge only
- I_rx_data  in  DATA_WIDTH  received byte, valid while I_rx_ready is high
- I_read  in  1  pop strobe from consumer; one entry per cycle it is high
- I_clear_overrun  in  1  clears O_overrun
- O_data  out  DATA_WIDTH  head entry (show-ahead); 0 when empty
- O_valid  out  1  FIFO not empty
- O_full  out  1  FIFO holds 2^DEPTH_LOG2 entries
- O_count  out  DEPTH_LOG2+1  number of stored entries, 0..2^DEPTH_LOG2
- O_overrun  out  1  sticky: a byte was dropped because the FIFO was full

## Operation
- Write detect: rx_prev register samples I_rx_ready each cycle; wr_req = I_rx_ready & ~rx_prev. A level held high for many cycles writes exactly once. rx_prev resets to 1, so a high level present at reset release does not write.
- Write: wr_req & ~O_full -> mem[wr_ptr] <= I_rx_data, wr_ptr increments, wrapping modulo depth.
- Write while full, with no read in the same cycle -> byte dropped, pointers unchanged, O_overrun <= 1.
- Read: I_read & O_valid -> rd_ptr increments, wrapping. I_read while empty is ignored; no pointer or flag change.
- Simultaneous wr_req and I_read:
  - Non-empty (full included): both happen, count unchanged, no overrun.
  - Empty: write happens, read ignored.
- Count: O_count = entries; +1 on write only, -1 on read only, unchanged on both or neither. Never exceeds depth or goes below 0.
- Flags: O_valid = (O_count != 0); O_full = (O_count == depth). Both are derived from registered count (or from pointers with an extra wrap bit); no combinational path from inputs.
- O_data = O_valid ? mem[rd_ptr] : 0. Memory contents are not reset.
- Overrun: set wins over I_clear_overrun in the same cycle. Otherwise I_clear_overrun clears it. FIFO contents are not affected by clear.
- Reset: pointers, count, O_overrun <= 0; rx_prev <= 1. Reset outputs: O_data 0, O_valid 0, O_full 0, O_count 0, O_overrun 0. Reset mid-stream discards all entries. Reset has priority over every other input.

## Timing
- Write latency: rising edge of I_rx_ready sampled at edge N -> O_valid, O_count and O_data reflect the new byte after edge N (visible in cycle N+1).
- Read: I_read high at edge N -> after edge N, O_data shows the next entry (or 0 if now empty) and O_count has decremented.
- Throughput: one write and one read per cycle. The receiver writes at most once per character (~10·CLKS_PER_BIT cycles).
- O_overrun rises in the cycle after the dropped write.

## Structure
- DATA_WIDTH default and the UART byte width constant go in the shared UART defines header. The receiver uses the same header.
- Sub-module sync_fifo: generic pointer/count/memory FIFO with wr_en, rd_en, full, empty, count. It is reusable later for a transmit buffer.
- uart_rx_fifo wraps sync_fifo and adds the rising-edge write detect, overrun logic and output gating.

## Test plan
- Reset then single pulse I_rx_ready with 0xA5 -> next cycle O_valid=1, O_data=0xA5, O_count=1. I_read one cycle -> O_valid=0, O_data=0, O_count=0.
- I_rx_ready held high 5 cycles with 0x3C -> exactly one entry, O_count=1.
- Write 16 bytes 0x00..0x0F -> O_full=1, O_count=16. 17th write 0xFF -> O_overrun=1, count stays 16. Read all 16 -> 0x00..0x0F in order; 0xFF never appears.
- Full FIFO, write 0x77 and I_read in the same cycle -> no overrun, count 16, the last entry read out is 0x77 (pointer wrap verified).
- Empty FIFO, write 0x11 and I_read in the same cycle -> count 1, O_data=0x11. I_read on empty FIFO -> count stays 0.
- O_overrun set, I_clear_overrun coinciding with a new drop -> stays 1. Clear alone -> 0. Assert I_reset while holding 8 bytes -> all outputs 0 the next cycle.
